mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Requester side of the MEM-stage data_mem port. Accepts one load/store at a time from the
//  pipeline and checks its funct3, alignment and range. It then drives data_mem's
//  addr/in/MemLen/MemRead/MemWrite strobes, waits the memory read latency, and returns
//  sign/zero-extended load data. Stalls the pipeline until the response is presented.
// PARAMETERS
//  ADDR_W  8  width of data_mem byte address; req_addr[31:ADDR_W] must be zero
//  RD_LAT  1  cycles from MemRead assertion to valid out (>=1)
// PORTS
//  clk           in   1       system clock, all logic on rising edge
//  rst           in   1       synchronous, active-high reset
//  req_valid     in   1       pipeline presents a memory op
//  req_write     in   1       1 = store, 0 = load
//  req_funct3    in   3       RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  req_addr      in   32      byte address
//  req_wdata     in   32      store data (right-justified)
//  req_ready     out  1       op accepted when req_valid & req_ready
//  stall         out  1       hold upstream pipeline registers
//  rsp_valid     out  1       one-cycle response strobe
//  rsp_rdata     out  32      extended load data; 0 for stores/faults
//  rsp_fault     out  1       misaligned/illegal/out-of-range op; qualified by rsp_valid
//  addr          out  ADDR_W  to data_mem addr
//  in            out  32      to data_mem in (unused bytes zeroed)
//  MemLen        out  3       to data_mem MemLen = latched funct3
//  MemRead       out  1       to data_mem MemRead
//  MemWrite      out  1       to data_mem MemWrite; write commits on rising clk edge
//  out           in   32      from data_mem, raw data right-justified
// BEHAVIOUR
//  Reset: state IDLE; addr/in/MemLen/rsp_rdata = 0; MemRead/MemWrite/rsp_valid/rsp_fault = 0.
//   After reset: req_ready = 1, stall = 0.
//  States: IDLE -> ACCESS -> RESP -> IDLE. A faulted op goes IDLE -> RESP.
//  IDLE: req_ready = 1. Accept on req_valid. Legal loads: funct3 in {0,1,2,4,5}. Legal stores:
//   {0,1,2}. Faults:
//   - illegal funct3
//   - half with addr[0] = 1
//   - word with addr[1:0] != 0
//   - req_addr[31:ADDR_W] != 0
//   On fault: next state RESP with rsp_fault = 1 and no MemRead/MemWrite ever asserted.
//  ACCESS (cycle after accept): addr/in/MemLen registered from the request and held stable.
//   - Store: MemWrite = 1 for exactly this one cycle, then RESP.
//   - Load: MemRead = 1 for RD_LAT cycles (counter). On the last edge, capture out into
//     rsp_rdata, then RESP.
//   - Extension: funct3 0 uses bit 7, 1 uses bit 15, 2 is full word; 4/5 zero-extend.
//  in masking: SB keeps [7:0], SH keeps [15:0], upper bits are 0.
//  RESP: rsp_valid = 1 for one cycle, req_ready = 0, then IDLE. No back-to-back acceptance.
//  Latency (RD_LAT=1): accept cycle N, ACCESS N+1, rsp_valid N+2. Load rsp at N+1+RD_LAT.
//   Fault rsp at N+1.
//  stall = (state==IDLE & req_valid) | state==ACCESS. It is 0 in RESP so the pipeline
//   consumes the response.
//  MemRead and MemWrite are never high together. Both are 0 outside ACCESS.
//  Reset mid-op: return to IDLE at that edge, strobes drop, no rsp_valid. A MemWrite high at
//   the reset edge still commits (memory samples that edge).
//  req_* are ignored when req_ready = 0.
// TESTING
//  1 LW addr=0x98 after SW 0x1 to 0x98: MemWrite one cycle at N+1, MemLen=2, in=0x00000001;
//    load rsp_rdata=0x00000001 at N+2.
//  2 SB 0xDEADBEEF to 0x99, then LB 0x99: in=0x000000EF; rsp_rdata=0xFFFFFFEF.
//    LBU 0x99 gives 0x000000EF.
//  3 LH addr=0x9B -> rsp_valid & rsp_fault at N+1, rsp_rdata=0, MemRead/MemWrite never high.
//  4 funct3=3 load, then req_addr=0x100 with ADDR_W=8 -> fault each, no memory strobe.
//  5 RD_LAT=3, LW 0x98 -> MemRead high 3 cycles, stall high 4 cycles, rsp_valid at N+4.
//  6 rst asserted in ACCESS of an LW -> IDLE next cycle, all strobes 0, no rsp_valid,
//    req_ready=1.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake between the MEM pipeline stage and the
// data_mem access controller.
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  req_ready, stall, rsp_valid, rsp_rdata, rsp_fault
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    output req_ready, stall, rsp_valid, rsp_rdata, rsp_fault
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Requester side of the MEM-stage data_mem port: one load/store in flight,
// funct3/alignment/range checking, data_mem strobe generation, load extension.
module mem_access_ctrl #(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_ctrl_if.slave  bus,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       in,
  output logic [2:0]        MemLen,
  output logic              MemRead,
  output logic              MemWrite,
  input  logic [31:0]       out
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           state, state_nxt;
  logic             write_p1;
  logic [CNT_W-1:0] cnt_p1;
  logic [31:0]      rdata_p2;
  logic             fault_p2;
  logic             acc_fault;
  logic             accept;
  logic             rd_last;

  // Any reason the op must not reach memory: bad funct3, misalignment, or
  // an address beyond the data_mem window.
  function automatic logic req_fault(input logic wr, input logic [2:0] f3,
                                     input logic [31:0] a);
    logic bad;
    bad = 1'b0;
    case (f3)
      3'd0:    bad = 1'b0;
      3'd1:    bad = a[0];
      3'd2:    bad = a[1] | a[0];
      3'd4:    bad = wr;
      3'd5:    bad = wr | a[0];
      default: bad = 1'b1;
    endcase
    if ((a >> ADDR_W) != 32'd0) bad = 1'b1;
    return bad;
  endfunction

  // Store data with the bytes outside the access width zeroed.
  function automatic logic [31:0] mask_store(input logic [2:0] f3,
                                             input logic [31:0] wdata);
    logic [31:0] m;
    case (f3)
      3'd0:    m = {24'd0, wdata[7:0]};
      3'd1:    m = {16'd0, wdata[15:0]};
      default: m = wdata;
    endcase
    return m;
  endfunction

  // Sign- or zero-extension of the raw right-justified read data.
  function automatic logic [31:0] extend_load(input logic [2:0] f3,
                                              input logic [31:0] raw);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] ext;
    b = raw[7:0];
    h = raw[15:0];
    case (f3)
      3'd0:    ext = b;
      3'd1:    ext = h;
      3'd4:    ext = {24'd0, raw[7:0]};
      3'd5:    ext = {16'd0, raw[15:0]};
      default: ext = raw;
    endcase
    return ext;
  endfunction

  assign acc_fault = req_fault(bus.req_write, bus.req_funct3, bus.req_addr);
  assign accept    = (state == IDLE) && bus.req_valid;
  assign rd_last   = (cnt_p1 == CNT_W'(RD_LAT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, handshake and data_mem strobes; strobes only ever in ACCESS.
  always_comb begin
    state_nxt     = state;
    bus.req_ready = 1'b0;
    bus.stall     = 1'b0;
    bus.rsp_valid = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        bus.stall     = bus.req_valid;
        if (bus.req_valid) state_nxt = acc_fault ? RESP : ACCESS;
      end
      ACCESS: begin
        bus.stall = 1'b1;
        if (write_p1) begin
          MemWrite  = 1'b1;
          state_nxt = RESP;
        end else begin
          MemRead = 1'b1;
          if (rd_last) state_nxt = RESP;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: request latched at accept and held through ACCESS.
  // Stage p2: response data captured on the last read edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr     <= '0;
      in       <= '0;
      MemLen   <= '0;
      write_p1 <= 1'b0;
      cnt_p1   <= '0;
      rdata_p2 <= '0;
      fault_p2 <= 1'b0;
    end else if (accept) begin
      addr     <= bus.req_addr[ADDR_W-1:0];
      in       <= bus.req_write ? mask_store(bus.req_funct3, bus.req_wdata) : 32'd0;
      MemLen   <= bus.req_funct3;
      write_p1 <= bus.req_write;
      cnt_p1   <= '0;
      rdata_p2 <= '0;
      fault_p2 <= acc_fault;
    end else if ((state == ACCESS) && !write_p1) begin
      cnt_p1 <= cnt_p1 + CNT_W'(1);
      if (rd_last) rdata_p2 <= extend_load(MemLen, out);
    end
  end

  assign bus.rsp_rdata = rdata_p2;
  assign bus.rsp_fault = fault_p2;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: DUT A (RD_LAT=1) with a byte memory model and a
// response/write scoreboard, DUT B (RD_LAT=3) sharing the memory for latency.
module tb_mem_access_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  mem_access_ctrl_if bus_a ();
  mem_access_ctrl_if bus_b ();

  logic [7:0]  addr_a, addr_b;
  logic [31:0] in_a, in_b, out_a, out_b;
  logic [2:0]  len_a, len_b;
  logic        rd_a, wr_a, rd_b, wr_b;

  mem_access_ctrl #(.ADDR_W(8), .RD_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .addr(addr_a), .in(in_a),
    .MemLen(len_a), .MemRead(rd_a), .MemWrite(wr_a), .out(out_a)
  );

  mem_access_ctrl #(.ADDR_W(8), .RD_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .addr(addr_b), .in(in_b),
    .MemLen(len_b), .MemRead(rd_b), .MemWrite(wr_b), .out(out_b)
  );

  // Byte-addressed little-endian data memory; upper bits of narrow reads are junk.
  logic [7:0] mem [256];

  function automatic logic [31:0] rd_raw(input logic [7:0] a, input logic [2:0] len);
    case (len[1:0])
      2'd0:    return {24'h5A5A5A, mem[a]};
      2'd1:    return {16'h5A5A, mem[a + 8'd1], mem[a]};
      default: return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
    endcase
  endfunction

  always @(posedge clk) begin
    if (wr_a) begin
      mem[addr_a] <= in_a[7:0];
      if (len_a[1:0] != 2'd0) mem[addr_a + 8'd1] <= in_a[15:8];
      if (len_a[1:0] == 2'd2) begin
        mem[addr_a + 8'd2] <= in_a[23:16];
        mem[addr_a + 8'd3] <= in_a[31:24];
      end
    end
  end

  assign out_a = rd_raw(addr_a, len_a);

  // B's data only becomes valid on the third consecutive MemRead cycle.
  int rdcnt_b = 0;
  always @(posedge clk) rdcnt_b <= rd_b ? rdcnt_b + 1 : 0;
  assign out_b = (rdcnt_b == 2) ? rd_raw(addr_b, len_b) : 32'h0BAD0BAD;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          acc;
    int          lat;
  } rsp_t;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
    logic [2:0]  len;
  } wr_t;

  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  int   rd_cycles = 0;
  int   wr_cycles = 0;
  int   exp_rd = 0;
  int   exp_wr = 0;
  logic mon_en = 1'b0;

  // Monitor for DUT A: pops expectations whenever a write strobe or a response appears.
  always @(negedge clk) begin
    rsp_t r;
    wr_t  w;
    if (mon_en) begin
      if (rd_a) rd_cycles++;
      if (wr_a) wr_cycles++;
      if (rd_a || wr_a) check("rd_wr_exclusive", {31'd0, rd_a & wr_a}, 32'd0);
      if (wr_a) begin
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: addr 0x%02h in 0x%08h", addr_a, in_a);
        end else begin
          w = wr_q.pop_front();
          check("wr_addr", {24'd0, addr_a}, {24'd0, w.a});
          check("wr_in", in_a, w.d);
          check("wr_len", {29'd0, len_a}, {29'd0, w.len});
        end
      end
      if (bus_a.rsp_valid) begin
        if (rsp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp: rdata 0x%08h fault %0d", bus_a.rsp_rdata, bus_a.rsp_fault);
        end else begin
          r = rsp_q.pop_front();
          check("rsp_rdata", bus_a.rsp_rdata, r.rdata);
          check("rsp_fault", {31'd0, bus_a.rsp_fault}, {31'd0, r.fault});
          check("rsp_latency", 32'(cyc - r.acc), 32'(r.lat));
          check("rsp_ready_low", {31'd0, bus_a.req_ready}, 32'd0);
          check("rsp_stall_low", {31'd0, bus_a.stall}, 32'd0);
        end
      end
    end
  end

  // Present one op to DUT A and wait until its response has been consumed.
  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_in,
                       input logic [31:0] exp_rdata, input logic exp_fault);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus_a.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus_a.req_ready) begin
      check("ready_timeout", {31'd0, bus_a.req_ready}, 32'd1);
      return;
    end
    rsp_q.push_back('{exp_rdata, exp_fault, cyc, exp_fault ? 1 : 2});
    if (!exp_fault && w) begin
      wr_q.push_back('{a[7:0], exp_in, f3});
      exp_wr++;
    end
    if (!exp_fault && !w) exp_rd++;
    bus_a.req_write  = w;
    bus_a.req_funct3 = f3;
    bus_a.req_addr   = a;
    bus_a.req_wdata  = wd;
    bus_a.req_valid  = 1'b1;
    @(negedge clk);
    bus_a.req_valid = 1'b0;
    n = 0;
    while (rsp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (rsp_q.size() != 0) begin
      check("rsp_timeout", 32'(rsp_q.size()), 32'd0);
      rsp_q.delete();
      wr_q.delete();
    end
  endtask

  initial begin
    int rdn, stn, wrn, rv_at;
    logic [31:0] rv_data;
    logic        rv_fault;

    bus_a.req_valid = 1'b0; bus_a.req_write = 1'b0; bus_a.req_funct3 = 3'd0;
    bus_a.req_addr  = 32'd0; bus_a.req_wdata = 32'd0;
    bus_b.req_valid = 1'b0; bus_b.req_write = 1'b0; bus_b.req_funct3 = 3'd0;
    bus_b.req_addr  = 32'd0; bus_b.req_wdata = 32'd0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, bus_a.req_ready}, 32'd1);
    check("rst_stall", {31'd0, bus_a.stall}, 32'd0);
    check("rst_rsp_valid", {31'd0, bus_a.rsp_valid}, 32'd0);
    check("rst_rsp_fault", {31'd0, bus_a.rsp_fault}, 32'd0);
    check("rst_rsp_rdata", bus_a.rsp_rdata, 32'd0);
    check("rst_addr", {24'd0, addr_a}, 32'd0);
    check("rst_in", in_a, 32'd0);
    check("rst_memlen", {29'd0, len_a}, 32'd0);
    check("rst_strobes", {30'd0, rd_a, wr_a}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Word, byte and half stores followed by loads with each extension
    issue(1'b1, 3'd2, 32'h98, 32'h0000_0001, 32'h0000_0001, 32'd0, 1'b0);
    issue(1'b0, 3'd2, 32'h98, 32'd0, 32'd0, 32'h0000_0001, 1'b0);
    issue(1'b1, 3'd0, 32'h99, 32'hDEAD_BEEF, 32'h0000_00EF, 32'd0, 1'b0);
    issue(1'b0, 3'd0, 32'h99, 32'd0, 32'd0, 32'hFFFF_FFEF, 1'b0);
    issue(1'b0, 3'd4, 32'h99, 32'd0, 32'd0, 32'h0000_00EF, 1'b0);
    issue(1'b1, 3'd1, 32'h9A, 32'hCAFE_BABE, 32'h0000_BABE, 32'd0, 1'b0);
    issue(1'b0, 3'd1, 32'h9A, 32'd0, 32'd0, 32'hFFFF_BABE, 1'b0);
    issue(1'b0, 3'd5, 32'h9A, 32'd0, 32'd0, 32'h0000_BABE, 1'b0);
    issue(1'b0, 3'd2, 32'h98, 32'd0, 32'd0, 32'hBABE_EF01, 1'b0);

    // Faults: misaligned, illegal funct3, out of range; none may touch memory
    issue(1'b0, 3'd1, 32'h9B, 32'd0, 32'd0, 32'd0, 1'b1);
    issue(1'b0, 3'd3, 32'h98, 32'd0, 32'd0, 32'd0, 1'b1);
    issue(1'b0, 3'd2, 32'h100, 32'd0, 32'd0, 32'd0, 1'b1);
    issue(1'b1, 3'd4, 32'h98, 32'h1234_5678, 32'd0, 32'd0, 1'b1);
    issue(1'b1, 3'd2, 32'h9A, 32'h1234_5678, 32'd0, 32'd0, 1'b1);
    issue(1'b0, 3'd5, 32'h99, 32'd0, 32'd0, 32'd0, 1'b1);
    issue(1'b0, 3'd2, 32'h98, 32'd0, 32'd0, 32'hBABE_EF01, 1'b0);

    // RD_LAT=3 word load on DUT B
    @(negedge clk);
    bus_b.req_write = 1'b0; bus_b.req_funct3 = 3'd2; bus_b.req_addr = 32'h98;
    bus_b.req_valid = 1'b1;
    rdn = 0; stn = 0; wrn = 0; rv_at = -1; rv_data = 32'd0; rv_fault = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (rd_b) rdn++;
      if (wr_b) wrn++;
      if (bus_b.stall) stn++;
      if (bus_b.rsp_valid && rv_at < 0) begin
        rv_at = k; rv_data = bus_b.rsp_rdata; rv_fault = bus_b.rsp_fault;
      end
      @(negedge clk);
      if (k == 0) bus_b.req_valid = 1'b0;
    end
    check("b_memread_cycles", 32'(rdn), 32'd3);
    check("b_stall_cycles", 32'(stn), 32'd4);
    check("b_memwrite_cycles", 32'(wrn), 32'd0);
    check("b_rsp_cycle", 32'(rv_at), 32'd4);
    check("b_rsp_rdata", rv_data, 32'hBABE_EF01);
    check("b_rsp_fault", {31'd0, rv_fault}, 32'd0);

    // Reset during ACCESS of a load on DUT A
    @(negedge clk);
    bus_a.req_write = 1'b0; bus_a.req_funct3 = 3'd2; bus_a.req_addr = 32'h98;
    bus_a.req_valid = 1'b1;
    exp_rd++;
    @(negedge clk);
    bus_a.req_valid = 1'b0;
    check("mid_access_memread", {31'd0, rd_a}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_ready", {31'd0, bus_a.req_ready}, 32'd1);
    check("mid_rst_strobes", {30'd0, rd_a, wr_a}, 32'd0);
    check("mid_rst_rsp_valid", {31'd0, bus_a.rsp_valid}, 32'd0);
    check("mid_rst_stall", {31'd0, bus_a.stall}, 32'd0);
    repeat (4) @(negedge clk);

    // Strobe totals and drained scoreboard
    check("memread_total", 32'(rd_cycles), 32'(exp_rd));
    check("memwrite_total", 32'(wr_cycles), 32'(exp_wr));
    check("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
    check("wr_q_drained", 32'(wr_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
